// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared opcode, state and flag definitions for the ALU op sequencer
package alu_seq_pkg;

  localparam int NUM_OPS = 10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_MOD = 4'd4,
    OP_AND = 4'd5,
    OP_OR  = 4'd6,
    OP_XOR = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op < 4'(NUM_OPS);
  endfunction

  // Only the arithmetic ops produce meaningful carry/overflow
  function automatic logic keeps_cv(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/alu_seq_result_mux.sv
// rtl/alu_seq_result_mux.sv - opcode-indexed selection of ALU result/flags with C/V masking
module alu_seq_result_mux
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [3:0]           op,
  input  logic [NUM_OPS*N-1:0] alu_res,
  input  logic [NUM_OPS*4-1:0] alu_flags,
  output logic [N-1:0]         data,
  output logic [3:0]           flags
);

  logic [3:0] raw;

  always_comb begin
    data  = '0;
    raw   = '0;
    flags = '0;
    for (int k = 0; k < NUM_OPS; k++) begin
      if (op == 4'(k)) begin
        data = alu_res[k*N +: N];
        raw  = alu_flags[k*4 +: 4];
      end
    end
    flags[FLAG_N] = raw[FLAG_N];
    flags[FLAG_Z] = raw[FLAG_Z];
    if (keeps_cv(op)) begin
      flags[FLAG_C] = raw[FLAG_C];
      flags[FLAG_V] = raw[FLAG_V];
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - request/response sequencer driving the ALU operand bus
// Optional counters: define ALU_SEQ_STATS_EN to enable stat_ops/stat_err.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int N        = 4,
  parameter int MULT_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [N-1:0]         req_a,
  input  logic [N-1:0]         req_b,
  input  logic                 req_cin,
  input  logic [$clog2(N):0]   req_shamt,
  output logic [N-1:0]         alu_a,
  output logic [N-1:0]         alu_b,
  output logic                 alu_cin,
  output logic [$clog2(N):0]   alu_shamt,
  input  logic [10*N-1:0]      alu_res,
  input  logic [39:0]          alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [N-1:0]         rsp_data,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_err
);

  localparam int CW = (MULT_LAT > 1) ? $clog2(MULT_LAT + 1) : 1;

  seq_state_e      state_q, state_d;
  logic [3:0]      op_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    sel_data;
  logic [3:0]      sel_flags;
  logic            accept;
  logic            rsp_fire;
  logic            exec_done;

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign accept    = req_valid && req_ready;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign exec_done = (state_q == EXEC) && (cnt_q == CW'(1));

  alu_seq_result_mux #(.N(N)) u_result_mux (
    .op        (op_q),
    .alu_res   (alu_res),
    .alu_flags (alu_flags),
    .data      (sel_data),
    .flags     (sel_flags)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = is_legal_op(req_op) ? EXEC : RESP;
      EXEC:    if (exec_done) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are captured only on accept so the ALU sees a stable bus until the next request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cin   <= 1'b0;
      alu_shamt <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        if (is_legal_op(req_op)) begin
          alu_a     <= req_a;
          alu_b     <= req_b;
          alu_cin   <= req_cin;
          alu_shamt <= req_shamt;
          op_q      <= req_op;
          cnt_q     <= (req_op == OP_MUL) ? CW'(MULT_LAT) : CW'(1);
        end else begin
          rsp_err   <= 1'b1;
          rsp_data  <= '0;
          rsp_flags <= '0;
        end
      end
      if (state_q == EXEC) begin
        cnt_q <= cnt_q - CW'(1);
        if (exec_done) begin
          rsp_data  <= sel_data;
          rsp_flags <= sel_flags;
          rsp_err   <= 1'b0;
        end
      end
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] ops_q;
  logic [15:0] err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_q <= '0;
      err_q <= '0;
    end else if (rsp_fire) begin
      if (ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
      if (rsp_err && (err_q != 16'hFFFF)) err_q <= err_q + 16'd1;
    end
  end

  assign stat_ops = ops_q;
  assign stat_err = err_q;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
  assign stat_ops    = '0;
  assign stat_err    = '0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - randomized self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

  localparam int N        = 4;
  localparam int MULT_LAT = 4;
  localparam int SW       = $clog2(N) + 1;
`ifdef ALU_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  logic [3:0]      req_op;
  logic [N-1:0]    req_a, req_b;
  logic            req_cin;
  logic [SW-1:0]   req_shamt;
  logic [N-1:0]    alu_a, alu_b;
  logic            alu_cin;
  logic [SW-1:0]   alu_shamt;
  logic [10*N-1:0] alu_res;
  logic [39:0]     alu_flags;
  logic            rsp_valid, rsp_ready;
  logic [N-1:0]    rsp_data;
  logic [3:0]      rsp_flags;
  logic            rsp_err;
  logic [15:0]     stat_ops, stat_err;

  int vectors     = 0;
  int miscompares = 0;

  logic [N-1:0]  m_a, m_b;
  logic          m_cin;
  logic [SW-1:0] m_sh;
  int            m_ops, m_err;

  always #5 clk = ~clk;

  alu_op_sequencer #(.N(N), .MULT_LAT(MULT_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_shamt(req_shamt),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_shamt(alu_shamt),
    .alu_res(alu_res), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .stat_ops(stat_ops), .stat_err(stat_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Plain arithmetic ALU; returns {N,Z,C,V,result}. Non-arithmetic ops report junk C/V on purpose.
  function automatic logic [N+3:0] alu_calc(input int op, input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic cin, input logic [SW-1:0] sh);
    logic [N:0]     w;
    logic [2*N-1:0] p;
    logic [N-1:0]   r;
    logic           c, v;
    w = '0; p = '0; r = '0; c = 1'b1; v = 1'b1;
    case (op)
      0: begin
        w = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        r = w[N-1:0]; c = w[N]; v = (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
      end
      1: begin
        w = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, cin};
        r = w[N-1:0]; c = w[N]; v = (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
      end
      2: begin
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        r = p[N-1:0]; c = |p[2*N-1:N]; v = c;
      end
      3: r = (b == 0) ? '1 : a / b;
      4: r = (b == 0) ? a : a % b;
      5: r = a & b;
      6: r = a | b;
      7: r = a ^ b;
      8: r = a << sh;
      9: r = a >> sh;
      default: r = '0;
    endcase
    return {r[N-1], (r == 0), c, v, r};
  endfunction

  always_comb begin
    logic [N+3:0] t;
    alu_res   = '0;
    alu_flags = '0;
    t         = '0;
    for (int k = 0; k < 10; k++) begin
      t = alu_calc(k, alu_a, alu_b, alu_cin, alu_shamt);
      alu_res[k*N +: N]   = t[N-1:0];
      alu_flags[k*4 +: 4] = t[N+3:N];
    end
  end

  task automatic expect_rsp(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic cin, input logic [SW-1:0] sh,
                            output logic [N-1:0] d, output logic [3:0] f, output logic e);
    logic [N+3:0] t;
    if (op > 4'd9) begin
      d = '0; f = '0; e = 1'b1;
    end else begin
      t = alu_calc(int'(op), a, b, cin, sh);
      d = t[N-1:0];
      f = t[N+3:N];
      if (op > 4'd2) f[1:0] = 2'b00;
      e = 1'b0;
    end
  endtask

  task automatic run_txn(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic cin, input logic [SW-1:0] sh, input int hold);
    logic [N-1:0] ed;
    logic [3:0]   ef;
    logic         ee;
    int           lat, explat;
    logic         busy_hi;
    expect_rsp(op, a, b, cin, sh, ed, ef, ee);
    explat = (op > 4'd9) ? 1 : (op == 4'd2) ? MULT_LAT + 1 : 2;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin; req_shamt = sh;
    @(posedge clk);
    #1;
    req_valid = $urandom_range(0, 1);
    req_op = 4'($urandom); req_a = N'($urandom); req_b = N'($urandom);
    req_cin = 1'($urandom); req_shamt = SW'($urandom);
    if (op <= 4'd9) begin
      m_a = a; m_b = b; m_cin = cin; m_sh = sh;
    end
    lat = 1;
    busy_hi = 1'b0;
    @(negedge clk);
    while (!rsp_valid && lat < 20) begin
      if (req_ready) busy_hi = 1'b1;
      rsp_ready = $urandom_range(0, 1);
      @(negedge clk);
      lat++;
    end
    rsp_ready = 1'b0;
    check("latency", 32'(lat), 32'(explat));
    check("req_ready_busy", 32'(busy_hi | req_ready), 32'd0);
    check("alu_a", 32'(alu_a), 32'(m_a));
    check("alu_b", 32'(alu_b), 32'(m_b));
    check("alu_cin", 32'(alu_cin), 32'(m_cin));
    check("alu_shamt", 32'(alu_shamt), 32'(m_sh));
    check("rsp_data", 32'(rsp_data), 32'(ed));
    check("rsp_flags", 32'(rsp_flags), 32'(ef));
    check("rsp_err", 32'(rsp_err), 32'(ee));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'(ed));
      check("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    if (m_ops < 16'hFFFF) m_ops++;
    if (ee && m_err < 16'hFFFF) m_err++;
    @(negedge clk);
    check("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    check("req_ready_back", 32'(req_ready), 32'd1);
    check("rsp_data_kept", 32'(rsp_data), 32'(ed));
    check("stat_ops", 32'(stat_ops), STATS ? 32'(m_ops) : 32'd0);
    check("stat_err", 32'(stat_err), STATS ? 32'(m_err) : 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_cin = 1'b0; req_shamt = '0;
    rsp_ready = 1'b0;
    m_a = '0; m_b = '0; m_cin = 1'b0; m_sh = '0; m_ops = 0; m_err = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_stat_ops", 32'(stat_ops), 32'd0);
    rst = 1'b0;

    run_txn(4'd0, 4'd3, 4'd4, 1'b0, '0, 0);
    run_txn(4'd1, 4'd2, 4'd5, 1'b0, '0, 0);
    run_txn(4'd2, 4'd3, 4'd3, 1'b0, '0, 0);
    run_txn(4'hB, 4'd9, 4'd1, 1'b1, 3'd2, 0);
    run_txn(4'd5, 4'hC, 4'hA, 1'b0, '0, 3);

    // Reset two cycles into a multiply aborts it
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd2; req_a = 4'd7; req_b = 4'd6;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    m_a = '0; m_b = '0; m_cin = 1'b0; m_sh = '0; m_ops = 0; m_err = 0;
    @(negedge clk);
    rst = 1'b0;
    run_txn(4'd7, 4'd5, 4'd3, 1'b0, '0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run_txn(op, N'($urandom), N'($urandom), 1'($urandom), SW'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the ALU operand/result interface.
- Accepts one operation request at a time over a valid/ready handshake and registers operands onto the ALU input bus.
- Waits the settle/multiplier latency, selects the result and flags for the opcode, and holds them on a valid/ready response port.
- Sits between the control/test front end (switches, UART, or FSM) and the ALU datapath.

Parameters:
- N, 4, operand/result width; must match the ALU instance.
- MULT_LAT, 4, cycles allowed for the sequential multiplier after operands are driven (>=1).

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; equals (state==IDLE).
- req_op  in  4  opcode (see Behaviour).
- req_a  in  N  operand A.
- req_b  in  N  operand B.
- req_cin  in  1  carry-in.
- req_shamt  in  $clog2(N)+1  shift amount.
- alu_a  out  N  registered operand A to ALU.
- alu_b  out  N  registered operand B to ALU.
- alu_cin  out  1  registered carry-in to ALU.
- alu_shamt  out  $clog2(N)+1  registered shift amount to ALU.
- alu_res  in  10*N  packed ALU results; slice k = opcode k.
- alu_flags  in  40  packed flags; slice k = {N,Z,C,V} for opcode k.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  N  selected result.
- rsp_flags  out  4  {N,Z,C,V}.
- rsp_err  out  1  illegal opcode.
- stat_ops  out  16  completed-response count (optional feature).
- stat_err  out  16  error-response count (optional feature).

Behaviour:
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR. Codes 10–15 are illegal.
- Reset (async, rst=1):
  - state=IDLE.
  - alu_a/alu_b/alu_shamt=0, alu_cin=0.
  - rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_err=0, counters=0.
  - req_ready=1 (combinational from IDLE).
- State IDLE:
  - Acceptance is req_valid&&req_ready at edge E0.
  - Legal op: latch operands into alu_* and the opcode into op_q. Load cnt=1, or MULT_LAT for MUL. Go to EXEC.
  - Illegal op: alu_* unchanged. Load rsp_err=1, rsp_data=0, rsp_flags=0. Go to RESP.
- State EXEC:
  - cnt decrements each cycle.
  - On the edge where cnt==1: capture rsp_data=alu_res[op_q] and rsp_flags=alu_flags[op_q], rsp_err=0, then go to RESP.
  - C and V are forced to 0 for every op except ADD, SUB and MUL.
- State RESP:
  - rsp_valid=1.
  - rsp_data/rsp_flags/rsp_err are stable until rsp_valid&&rsp_ready.
  - That edge clears rsp_valid and returns to IDLE.
  - rsp_data/rsp_flags/rsp_err keep their last value after the handshake.
- Latency from E0 to rsp_valid high:
  - 2 cycles for non-MUL legal ops.
  - MULT_LAT+1 cycles for MUL.
  - 1 cycle for illegal ops.
- Throughput: req_ready is 0 in EXEC/RESP. Minimum spacing between accepts is latency+1 cycles (rsp_ready tied 1).
- alu_* holds its value after capture. The ALU inputs change only on accept.
- req_* changes while req_ready=0 are ignored.
- Reset mid-EXEC or mid-RESP: the transaction is aborted and no response is produced. The first request after reset behaves normally.
- rsp_ready asserted outside RESP is ignored.

Optional Feature:
- Macro ALU_SEQ_STATS_EN.
- Defined:
  - stat_ops increments on every rsp_valid&&rsp_ready.
  - stat_err also increments when rsp_err=1.
  - Both counters saturate at 16'hFFFF and are cleared only by rst.
- Undefined: stat_ops and stat_err are tied to 0 and no counter flops exist.

Decomposition:
- Package alu_seq_pkg:
  - alu_op_e enum (10 opcodes).
  - seq_state_e {IDLE, EXEC, RESP}.
  - NUM_OPS=10.
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - Function is_legal_op.
- One sub-module, alu_seq_result_mux: combinational opcode-indexed slice selection plus C/V masking.

Test Plan (N=4, MULT_LAT=4):
- ADD a=3, b=4, cin=0 -> rsp_data=7, rsp_flags=4'b0000, rsp_valid 2 cycles after accept; alu_a=3, alu_b=4.
- SUB a=2, b=5 -> rsp_data=4'hD, rsp_flags[N]=1, rsp_err=0.
- MUL a=3, b=3 -> rsp_valid exactly 5 cycles after accept, rsp_data=9; req_ready=0 throughout.
- req_op=4'hB -> rsp_valid 1 cycle after accept, rsp_err=1, rsp_data=0; with ALU_SEQ_STATS_EN, stat_err=1 after handshake.
- AND a=4'hC, b=4'hA with rsp_ready low 3 cycles -> rsp_data=8 stable, rsp_valid held, req_ready=0; clears the cycle after rsp_ready.
- rst pulse 2 cycles into MUL -> rsp_valid=0, req_ready=1, alu_a=0; following XOR 5^3 returns 6.
